// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer state encoding and per-opcode latency.
// Used by the ALU, the control unit and alu_op_sequencer.
package alu_pkg;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_SHR = 5'b00101;
   localparam logic [4:0] OP_SHL = 5'b00110;
   localparam logic [4:0] OP_ROR = 5'b00111;
   localparam logic [4:0] OP_ROL = 5'b01000;
   localparam logic [4:0] OP_AND = 5'b01001;
   localparam logic [4:0] OP_OR  = 5'b01010;
   localparam logic [4:0] OP_MUL = 5'b01110;
   localparam logic [4:0] OP_DIV = 5'b01111;
   localparam logic [4:0] OP_NEG = 5'b10000;
   localparam logic [4:0] OP_NOT = 5'b10001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic is_legal(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
         OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: is_legal = 1'b1;
         default:                                        is_legal = 1'b0;
      endcase
   endfunction

   // Cycles the ALU inputs must be held for a given opcode (1..15).
   function automatic logic [3:0] lat_of(input logic [4:0] op,
                                         input int mul_cycles,
                                         input int div_cycles);
      case (op)
         OP_MUL:  lat_of = 4'(mul_cycles);
         OP_DIV:  lat_of = 4'(div_cycles);
         default: lat_of = 4'd1;
      endcase
   endfunction

endpackage

// File: rtl/alu_latency_counter.sv
// 4-bit down-counter: load sets the count, en decrements it, zero flags count==0.
// Holds at zero rather than wrapping.
module alu_latency_counter (
   input  logic       clk,
   input  logic       clear,
   input  logic       load,
   input  logic       en,
   input  logic [3:0] load_val,
   output logic       zero
);

   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign zero = (cnt == 4'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU front-end sequencer: one op in flight, IDLE -> EXEC -> RESP with per-opcode latency.
// Optional `ALU_DIV_ZERO_CHECK_EN short-circuits DIV by zero and adds the rsp_div0 output.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_opcode,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_opcode,
   input  logic [63:0] alu_c,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_hi,
   output logic [31:0] rsp_lo,
   output logic        rsp_illegal,
`ifdef ALU_DIV_ZERO_CHECK_EN
   output logic        rsp_div0,
`endif
   output logic        busy,
   output state_t      dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // producers hold payload stable while valid is high and ready is low.

   state_t      state_q, state_d;
   logic        accept, legal, div_zero, load, capture, cnt_zero;
   logic [31:0] a_q, b_q;
   logic [4:0]  op_q;

   assign accept = req_valid && (state_q == IDLE);
   assign legal  = is_legal(req_opcode);

`ifdef ALU_DIV_ZERO_CHECK_EN
   assign div_zero = (req_opcode == OP_DIV) && (req_b == 32'd0);
`else
   assign div_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (legal && !div_zero) begin
                  state_d = EXEC;
                  load    = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end
         end
         EXEC: begin
            if (cnt_zero) begin
               state_d = RESP;
               capture = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   alu_latency_counter u_cnt (
      .clk      (clk),
      .clear    (clear),
      .load     (load),
      .en       (state_q == EXEC),
      .load_val (lat_of(req_opcode, MUL_CYCLES, DIV_CYCLES) - 4'd1),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         op_q        <= 5'd0;
         rsp_hi      <= 32'd0;
         rsp_lo      <= 32'd0;
         rsp_illegal <= 1'b0;
`ifdef ALU_DIV_ZERO_CHECK_EN
         rsp_div0    <= 1'b0;
`endif
      end else if (accept) begin
         a_q         <= req_a;
         b_q         <= req_b;
         op_q        <= req_opcode;
         // Short-circuited responses (illegal, div0) get their final value here.
         rsp_hi      <= div_zero ? 32'hFFFF_FFFF : 32'd0;
         rsp_lo      <= div_zero ? 32'hFFFF_FFFF : 32'd0;
         rsp_illegal <= !legal;
`ifdef ALU_DIV_ZERO_CHECK_EN
         rsp_div0    <= div_zero;
`endif
      end else if (capture) begin
         rsp_hi      <= alu_c[63:32];
         rsp_lo      <= alu_c[31:0];
      end
   end

   // The ALU sees zeros whenever it is not executing.
   assign alu_a      = (state_q == EXEC) ? a_q  : 32'd0;
   assign alu_b      = (state_q == EXEC) ? b_q  : 32'd0;
   assign alu_opcode = (state_q == EXEC) ? op_q : 5'd0;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and an expected-result queue.
// Works with or without ALU_DIV_ZERO_CHECK_EN defined.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int MUL_CYC = 4;
   localparam int DIV_CYC = 8;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_opcode = 5'd0;
   logic [31:0] req_a = 32'd0;
   logic [31:0] req_b = 32'd0;
   logic [31:0] alu_a, alu_b;
   logic [4:0]  alu_opcode;
   logic [63:0] alu_c;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_hi, rsp_lo;
   logic        rsp_illegal;
   logic        busy;
   state_t      dbg_state;
   logic        div0_obs;

   int checks = 0;
   int errors = 0;

   // {div0, illegal, hi, lo}
   logic [65:0] exp_q[$];

   always #5 clk = ~clk;

   function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_ADD:  alu_model = {32'd0, a + b};
         OP_SUB:  alu_model = {32'd0, a - b};
         OP_SHR:  alu_model = {32'd0, a >> b[4:0]};
         OP_SHL:  alu_model = {32'd0, a << b[4:0]};
         OP_ROR:  alu_model = {32'd0, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
         OP_ROL:  alu_model = {32'd0, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
         OP_AND:  alu_model = {32'd0, a & b};
         OP_OR:   alu_model = {32'd0, a | b};
         OP_MUL:  alu_model = 64'(a) * 64'(b);
         OP_DIV:  alu_model = (b != 32'd0) ? {a % b, a / b} : {a, 32'hFFFF_FFFF};
         OP_NEG:  alu_model = {32'd0, 32'd0 - a};
         OP_NOT:  alu_model = {32'd0, ~a};
         default: alu_model = 64'd0;
      endcase
   endfunction

   assign alu_c = alu_model(alu_opcode, alu_a, alu_b);

   alu_op_sequencer #(
      .MUL_CYCLES (MUL_CYC),
      .DIV_CYCLES (DIV_CYC)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_opcode  (req_opcode),
      .req_a       (req_a),
      .req_b       (req_b),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_opcode  (alu_opcode),
      .alu_c       (alu_c),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_hi      (rsp_hi),
      .rsp_lo      (rsp_lo),
      .rsp_illegal (rsp_illegal),
`ifdef ALU_DIV_ZERO_CHECK_EN
      .rsp_div0    (div0_obs),
`endif
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

`ifndef ALU_DIV_ZERO_CHECK_EN
   assign div0_obs = 1'b0;
`endif

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".req_ready"}, 66'(req_ready), 66'd1);
      chk({tag, ".rsp_valid"}, 66'(rsp_valid), 66'd0);
      chk({tag, ".busy"}, 66'(busy), 66'd0);
      chk({tag, ".alu"}, 66'({alu_opcode, alu_a, alu_b}), 66'd0);
   endtask

   // Issue one op, check ALU drive and latency, hold back-pressure, then drain.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [65:0] exp, input int exp_lat,
                         input int hold);
      int n;
      logic [65:0] e;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".ready_before"}, 66'(req_ready), 66'd1);
      req_valid  = 1'b1;
      req_opcode = op;
      req_a      = a;
      req_b      = b;
      exp_q.push_back(exp);
      @(negedge clk);
      req_valid  = 1'b0;
      req_opcode = 5'($urandom_range(0, 31));
      req_a      = $urandom;
      req_b      = $urandom;
      n = 1;
      while (!rsp_valid && n <= 40) begin
         chk({tag, ".exec_op"}, 66'(alu_opcode), 66'(op));
         chk({tag, ".exec_ab"}, 66'({alu_a, alu_b}), 66'({a, b}));
         chk({tag, ".exec_ready"}, 66'(req_ready), 66'd0);
         @(negedge clk);
         n++;
      end
      chk({tag, ".latency"}, 66'(n), 66'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         req_valid  = 1'b1;
         req_opcode = OP_ADD;
         chk({tag, ".hold_valid"}, 66'(rsp_valid), 66'd1);
         chk({tag, ".hold_ready"}, 66'(req_ready), 66'd0);
         chk({tag, ".hold_data"}, {div0_obs, rsp_illegal, rsp_hi, rsp_lo}, exp);
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk({tag, ".resp_alu_idle"}, 66'(alu_opcode), 66'd0);
      if (exp_q.size() == 0) begin
         chk({tag, ".queue_empty"}, 66'(exp_q.size()), 66'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".result"}, {div0_obs, rsp_illegal, rsp_hi, rsp_lo}, e);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk_idle_outputs({tag, ".drain"});
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [4:0]  rop;
      logic [4:0]  simple_ops[10];
      simple_ops = '{OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR, OP_NEG, OP_NOT};

      // Power-on reset
      repeat (2) @(negedge clk);
      clear = 1'b0;
      chk_idle_outputs("reset");
      chk("reset.rsp_data", {div0_obs, rsp_illegal, rsp_hi, rsp_lo}, 66'd0);

      // Clear in the middle of a MUL discards it
      req_valid = 1'b1; req_opcode = OP_MUL; req_a = 32'd9; req_b = 32'd9;
      @(negedge clk);
      req_valid = 1'b0;
      chk("midreset.exec", 66'(alu_opcode), 66'(OP_MUL));
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      chk("midreset.clear1", 66'(rsp_valid), 66'd0);
      @(negedge clk);
      clear = 1'b0;
      chk_idle_outputs("midreset.after");
      chk("midreset.rsp_data", {div0_obs, rsp_illegal, rsp_hi, rsp_lo}, 66'd0);
      for (int i = 0; i < 8; i++) begin
         chk("midreset.no_rsp", 66'(rsp_valid), 66'd0);
         @(negedge clk);
      end

      // Directed ops with literal expectations
      run_op("add", OP_ADD, 32'd5, 32'd7, {2'b00, 32'd0, 32'd12}, 2, 0);
      run_op("mul", OP_MUL, 32'd3, 32'd4, {2'b00, 32'd0, 32'd12}, MUL_CYC + 1, 0);
      run_op("mulbig", OP_MUL, 32'hFFFF_FFFF, 32'd2, {2'b00, 32'd1, 32'hFFFF_FFFE}, MUL_CYC + 1, 1);
      run_op("illegal", 5'b11111, 32'd1, 32'd2, {2'b01, 64'd0}, 1, 2);
      run_op("illegal0", 5'b00000, 32'd1, 32'd2, {2'b01, 64'd0}, 1, 0);
      run_op("div_bp", OP_DIV, 32'd100, 32'd7, {2'b00, 32'd2, 32'd14}, DIV_CYC + 1, 10);
      run_op("after_bp", OP_SUB, 32'd3, 32'd5, {2'b00, 32'd0, 32'hFFFF_FFFE}, 2, 0);

`ifdef ALU_DIV_ZERO_CHECK_EN
      run_op("div0", OP_DIV, 32'd55, 32'd0, {2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1, 1);
`else
      run_op("div0", OP_DIV, 32'd55, 32'd0, {2'b00, 32'd55, 32'hFFFF_FFFF}, DIV_CYC + 1, 1);
`endif

      // Random simple ops checked against the behavioural ALU
      for (int i = 0; i < 12; i++) begin
         rop = simple_ops[$urandom_range(0, 9)];
         ra  = $urandom;
         rb  = $urandom;
         run_op("rand", rop, ra, rb, {2'b00, alu_model(rop, ra, rb)}, 2, $urandom_range(0, 2));
      end

      chk("queue_drained", 66'(exp_q.size()), 66'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
